// File: rtl/adam_pause_resp_pkg.sv
// Shared types and helpers for the ADAM_PAUSE responder: FSM state encoding
// and the bit-width helper used to size the saturating counters.
package adam_pause_resp_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2,
        PAUSED = 2'd3
    } pauseState_t;

    // Bits needed to hold values 0..maxCount inclusive (never less than 1).
    function automatic int cntWidth(input int maxCount);
        return (maxCount < 1) ? 1 : $clog2(maxCount + 1);
    endfunction

endpackage

// File: rtl/adam_pause_txn_cnt.sv
// Saturating in-flight transaction counter with a sticky error flag that
// latches overflow, underflow and externally flagged protocol violations.
module adam_pause_txn_cnt
    import adam_pause_resp_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_inc,
    input  logic                                i_dec,
    input  logic                                i_viol,
    output logic [cntWidth(MAX_OUTSTANDING)-1:0] o_count,
    output logic                                o_err
);

    localparam int CW = cntWidth(MAX_OUTSTANDING);

    logic [CW-1:0] r_count;
    logic          r_err;
    logic [CW-1:0] w_nextCount;
    logic          w_fault;

    always_comb begin
        w_nextCount = r_count;
        w_fault     = i_viol;
        if (i_inc && !i_dec) begin
            if (r_count == CW'(MAX_OUTSTANDING)) begin
                w_fault = 1'b1;
            end else begin
                w_nextCount = r_count + CW'(1);
            end
        end else if (i_dec && !i_inc) begin
            if (r_count == '0) begin
                w_fault = 1'b1;
            end else begin
                w_nextCount = r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_nextCount;
            r_err   <= r_err | w_fault;
        end
    end

    assign o_count = r_count;
    assign o_err   = r_err;

endmodule

// File: rtl/adam_pause_resp.sv
// ADAM_PAUSE responder: gates and drains local transactions on pause request,
// acks after a settle delay. Optional drain timeout: ADAM_PAUSE_RESP_TIMEOUT_EN.
module adam_pause_resp
    import adam_pause_resp_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8,
    parameter int SETTLE_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_pause_req,
    output logic                                o_pause_ack,
    input  logic                                i_txn_start,
    input  logic                                i_txn_done,
    output logic                                o_gate,
    output logic [cntWidth(MAX_OUTSTANDING)-1:0] o_outstanding,
    output logic                                o_err,
    output logic                                o_timeout
);

    localparam int CW          = cntWidth(MAX_OUTSTANDING);
    localparam int SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int SW          = cntWidth(SETTLE_LOAD);

    if (MAX_OUTSTANDING < 1 || SETTLE_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_badParams
        $error("adam_pause_resp: illegal parameter values");
    end

    pauseState_t   r_state;
    pauseState_t   w_next;
    logic          r_ack;
    logic          r_gate;
    logic [SW-1:0] r_settleCnt;
    logic [CW-1:0] w_count;
    logic          w_drained;

    adam_pause_txn_cnt #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_txnCnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_inc  (i_txn_start),
        .i_dec  (i_txn_done),
        .i_viol (i_txn_start & r_gate),
        .o_count(w_count),
        .o_err  (o_err)
    );

    assign w_drained = (w_count == '0) && !i_txn_start;

`ifdef ADAM_PAUSE_RESP_TIMEOUT_EN
    localparam int TW = cntWidth(TIMEOUT_CYCLES);

    logic [TW-1:0] r_drainCnt;
    logic          r_timeout;
    logic          w_tmoHit;

    assign w_tmoHit = (r_state == DRAIN) && i_pause_req && !w_drained &&
                      (w_count != '0) && (r_drainCnt == TW'(TIMEOUT_CYCLES - 1));

    // Drain counter only advances on edges spent waiting with work still in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drainCnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_next != DRAIN) begin
                r_drainCnt <= '0;
            end else if (r_state == DRAIN && w_count != '0) begin
                r_drainCnt <= r_drainCnt + TW'(1);
            end
            if (w_next == RUN) begin
                r_timeout <= 1'b0;
            end else if (w_tmoHit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    logic w_tmoHit;
    assign w_tmoHit  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN: begin
                if (i_pause_req) w_next = DRAIN;
            end
            DRAIN: begin
                if (!i_pause_req) begin
                    w_next = RUN;
                end else if (w_drained || w_tmoHit) begin
                    w_next = (SETTLE_CYCLES == 0) ? PAUSED : SETTLE;
                end
            end
            SETTLE: begin
                if (!i_pause_req) begin
                    w_next = RUN;
                end else if (i_txn_start) begin
                    w_next = DRAIN;
                end else if (r_settleCnt == '0) begin
                    w_next = PAUSED;
                end
            end
            PAUSED: begin
                if (!i_pause_req) w_next = RUN;
            end
            default: w_next = PAUSED;
        endcase
    end

    // Outputs are registered from the next state so ack/gate change on the same edge as the state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= PAUSED;
            r_ack   <= 1'b1;
            r_gate  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_ack   <= (w_next == PAUSED);
            r_gate  <= (w_next != RUN);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_settleCnt <= '0;
        end else if (w_next == SETTLE && r_state != SETTLE) begin
            r_settleCnt <= SW'(SETTLE_LOAD);
        end else if (r_state == SETTLE && r_settleCnt != '0) begin
            r_settleCnt <= r_settleCnt - SW'(1);
        end
    end

    assign o_pause_ack   = r_ack;
    assign o_gate        = r_gate;
    assign o_outstanding = w_count;

endmodule

// File: tb/tb_adam_pause_resp.sv
// Self-checking bench for adam_pause_resp: directed handshake scenarios plus
// randomized traffic compared every cycle against a quiet-run reference model.
module tb_adam_pause_resp;
    import adam_pause_resp_pkg::*;

    localparam int MAXO = 8;
    localparam int SETC = 2;
    localparam int TMO  = 16;
    localparam int CW   = cntWidth(MAXO);

    logic          clk = 1'b0;
    logic          rst, req, start, done;
    logic          ack, gate, err, tmo;
    logic [CW-1:0] outst;

    int errors = 0;
    int checks = 0;

    // Reference model: pause progress is tracked as a run of quiet edges
    // (no new starts once empty); ack rises when the run reaches SETC+1.
    int mCnt, mQuiet, mWait;
    bit mAck, mGate, mErr, mTmo;

    always #5 clk = ~clk;

    adam_pause_resp #(
        .MAX_OUTSTANDING(MAXO),
        .SETTLE_CYCLES  (SETC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_pause_req  (req),
        .o_pause_ack  (ack),
        .i_txn_start  (start),
        .i_txn_done   (done),
        .o_gate       (gate),
        .o_outstanding(outst),
        .o_err        (err),
        .o_timeout    (tmo)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit q, input bit s, input bit d);
        int oldCnt;
        oldCnt = mCnt;
        if (r) begin
            mAck = 1; mGate = 1; mCnt = 0; mErr = 0; mTmo = 0; mQuiet = 0; mWait = 0;
        end else begin
            if (s && mGate) mErr = 1;
            if (s && !d) begin
                if (mCnt == MAXO) mErr = 1; else mCnt++;
            end else if (d && !s) begin
                if (mCnt == 0) mErr = 1; else mCnt--;
            end
            if (mAck) begin
                if (!q) begin mAck = 0; mGate = 0; mTmo = 0; end
            end else if (!mGate) begin
                if (q) begin mGate = 1; mQuiet = 0; mWait = 0; end
            end else if (!q) begin
                mGate = 0; mTmo = 0;
            end else begin
                if (mQuiet == 0) begin
                    if (oldCnt == 0 && !s) begin
                        mQuiet = 1;
                    end else if (oldCnt != 0) begin
                        mWait++;
`ifdef ADAM_PAUSE_RESP_TIMEOUT_EN
                        if (mWait == TMO) begin mQuiet = 1; mTmo = 1; end
`endif
                    end
                end else if (s) begin
                    mQuiet = 0; mWait = 0;
                end else begin
                    mQuiet++;
                end
                if (mQuiet == SETC + 1) mAck = 1;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit q, input bit s, input bit d);
        rst = r; req = q; start = s; done = d;
        @(posedge clk);
        modelStep(r, q, s, d);
        #1;
        checkOutput("ack", ack, mAck);
        checkOutput("gate", gate, mGate);
        checkOutput("outstanding", outst, mCnt);
        checkOutput("err", err, mErr);
        checkOutput("timeout", tmo, mTmo);
    endtask

    initial begin
        int n;
        bit q, s, d, r;
        rst = 1; req = 0; start = 0; done = 0;

        // Reset, stay paused while req held, then release.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("rstAck", ack, 1);
        checkOutput("rstGate", gate, 1);
        checkOutput("rstOutst", outst, 0);
        checkOutput("rstErr", err, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("resumeAck", ack, 0);
        checkOutput("resumeGate", gate, 0);

        // Empty block: edges from request edge k through the ack edge.
        applyStimulus(0, 0, 0, 0);
        n = 0;
        do begin applyStimulus(0, 1, 0, 0); n++; if (n == 1) checkOutput("gateAtK", gate, 1); end
        while (!ack && n < 50);
        checkOutput("ackLatency", n, SETC + 2);

        // Three in flight: ack held until drained, then SETC+1 edges after last done.
        applyStimulus(0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 1, 0);
        checkOutput("threeOut", outst, 3);
        repeat (6) applyStimulus(0, 1, 0, 0);
        checkOutput("ackHeld", ack, 0);
        repeat (3) applyStimulus(0, 1, 0, 1);
        checkOutput("drainedOut", outst, 0);
        n = 0;
        do begin applyStimulus(0, 1, 0, 0); n++; end while (!ack && n < 50);
        checkOutput("ackAfterDone", n, SETC + 1);

        // Gate violation, underflow, then saturation.
        applyStimulus(0, 1, 1, 0);
        checkOutput("violErr", err, 1);
        checkOutput("violOut", outst, 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 1);
        checkOutput("underflowOut", outst, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        repeat (9) applyStimulus(0, 0, 1, 0);
        checkOutput("satOut", outst, MAXO);
        checkOutput("satErr", err, 1);

        // Withdraw during settle: back to run, ack never rises.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("withdrawAck", ack, 0);
        checkOutput("withdrawGate", gate, 0);

        // Reset in drain with two outstanding.
        repeat (2) applyStimulus(0, 0, 1, 0);
        repeat (3) applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("rstDrainAck", ack, 1);
        checkOutput("rstDrainOut", outst, 0);

        // One transaction never completes while pause is requested.
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        n = 0;
`ifdef ADAM_PAUSE_RESP_TIMEOUT_EN
        do begin applyStimulus(0, 1, 0, 0); n++; end while (!tmo && n < 100);
        checkOutput("tmoEdges", n, TMO + 1);
        n = 0;
        do begin applyStimulus(0, 1, 0, 0); n++; end while (!ack && n < 50);
        checkOutput("tmoAckDelay", n, SETC);
        applyStimulus(0, 0, 0, 0);
        checkOutput("tmoCleared", tmo, 0);
`else
        repeat (3 * TMO) applyStimulus(0, 1, 0, 0);
        checkOutput("noTmoAck", ack, 0);
        checkOutput("noTmo", tmo, 0);
`endif
        applyStimulus(1, 0, 0, 0);

        // Randomized traffic.
        q = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(11) == 0) q = !q;
            r = ($urandom_range(199) == 0);
            s = mGate ? ($urandom_range(39) == 0) : ($urandom_range(9) < 3);
            d = (mCnt > 0) ? ($urandom_range(9) < 3) : ($urandom_range(39) == 0);
            applyStimulus(r, q, s, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
